muldiv_unit: RTL

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit; next generation of the single-cycle combinational M-extension ALU path.
- Sits beside the integer ALU in the execute stage. The controller dispatches OP-type instructions with funct7 = 0x01 to it via a valid/ready handshake.
- Computes one result bit per cycle with shift-add / restoring-divide datapaths.
- Divide-by-zero and signed overflow follow the RISC-V spec and take a single-cycle fast path.

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle; divide-by-zero and signed overflow resolve on accept.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            busy
);
    localparam logic [2:0] F_MUL   = 3'd0;
    localparam logic [2:0] F_MULHU = 3'd3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]        op_r;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic [CNT_W-1:0]  cnt;

    logic              sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;
    logic              accept, last_step;

    // Operand decode on the request side; only used in the accept cycle
    always_comb begin
        sgn_a_in = funct3[2] ? ~funct3[0] : (funct3 != F_MULHU);
        sgn_b_in = funct3[2] ? ~funct3[0] : ~funct3[1];
        neg_a_in = sgn_a_in & rs1[XLEN-1];
        neg_b_in = sgn_b_in & rs2[XLEN-1];
        mag_a_in = neg_a_in ? -rs1 : rs1;
        mag_b_in = neg_b_in ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = funct3[1] ? rs1 : '1;
        end else begin
            fast_res = funct3[1] ? '0 : rs1;
        end
    end

    logic [2*XLEN:0]   shifted;
    logic [XLEN:0]     trial_hi;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;

    // Divide keeps {remainder, dividend/quotient} in acc and shifts it left each step
    always_comb begin
        shifted  = {acc, 1'b0};
        trial_hi = shifted[2*XLEN:XLEN] - {1'b0, opb};
        if (op_r[2]) begin
            if (shifted[2*XLEN:XLEN] >= {1'b0, opb}) begin
                acc_step = {trial_hi[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
            end else begin
                acc_step = shifted[2*XLEN-1:0];
            end
        end else begin
            acc_step = opb[0] ? acc + mcand : acc;
        end
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (op_r[2]) begin
            res = op_r[1] ? rem : quo;
        end else begin
            res = (op_r == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~kill;
                if (in_valid && !kill) begin
                    state_nxt = fast ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (kill) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(XLEN - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (kill || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (state == CALC) && !kill && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            opb   <= '0;
            cnt   <= '0;
            rd    <= '0;
        end else if (accept) begin
            op_r  <= funct3;
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
            opb   <= mag_b_in;
            cnt   <= '0;
            if (funct3[2]) begin
                acc   <= {{XLEN{1'b0}}, mag_a_in};
                mcand <= '0;
            end else begin
                acc   <= '0;
                mcand <= {{XLEN{1'b0}}, mag_a_in};
            end
            if (fast) begin
                rd <= fast_res;
            end
        end else if (state == CALC && !kill) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
            if (!op_r[2]) begin
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
            if (last_step) begin
                rd <= res;
            end
        end
    end
endmodule
